// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for the debug-UART receive path
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam logic [7:0] ESC_BYTE = 8'hB1;

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [2:0] {
    PHY_IDLE      = 3'd0,
    PHY_START     = 3'd1,
    PHY_BITS      = 3'd2,
    PHY_PARITY    = 3'd3,
    PHY_STOP      = 3'd4,
    PHY_WAIT_IDLE = 3'd5
  } rx_phy_state_e;

  typedef enum logic [0:0] {
    S_DATA = 1'b0,
    S_ESC  = 1'b1
  } esc_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_phy.sv
`default_nettype none
// ============================================================================
// uart_rx_phy : RXD synchronizer + 8N1 bit FSM (8E1 when UART_RX_PARITY_EN)
// Rev 1.0
// ============================================================================
module uart_rx_phy
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       RXD_I,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] C_HALF_TICK = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] C_FULL_TICK = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_phy_state_e C_AFTER_BITS = PHY_PARITY;
`else
  localparam rx_phy_state_e C_AFTER_BITS = PHY_STOP;
`endif

  logic [1:0]    r_sync;
  logic          r_rxd_prev;
  logic          w_rxd;
  rx_phy_state_e r_state;
  rx_phy_state_e w_state_nxt;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_tick_half;
  logic          w_tick_full;
  logic          w_byte_valid;
  logic          w_frame_err;
  logic          w_parity_err;
  logic          w_par_ok;

  assign w_rxd       = r_sync[1];
  assign w_tick_half = (r_cnt == C_HALF_TICK);
  assign w_tick_full = (r_cnt == C_FULL_TICK);

  // Flops reset to the idle level so release from reset never looks like a start edge
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], RXD_I};
      r_rxd_prev <= w_rxd;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_state <= PHY_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PHY_IDLE:      if (r_rxd_prev && !w_rxd) w_state_nxt = PHY_START;
      PHY_START:     if (w_tick_half) w_state_nxt = w_rxd ? PHY_IDLE : PHY_BITS;
      PHY_BITS:      if (w_tick_full && (r_bit_idx == 3'd7)) w_state_nxt = C_AFTER_BITS;
      PHY_PARITY:    if (w_tick_full) w_state_nxt = PHY_STOP;
      PHY_STOP:      if (w_tick_full) w_state_nxt = w_rxd ? PHY_IDLE : PHY_WAIT_IDLE;
      PHY_WAIT_IDLE: if (w_rxd) w_state_nxt = PHY_IDLE;
      default:       w_state_nxt = PHY_IDLE;
    endcase
  end

  always_comb begin
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    if ((r_state == PHY_STOP) && w_tick_full) begin
      w_byte_valid = w_rxd & w_par_ok;
      w_frame_err  = ~w_rxd;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;

  // Even parity: data bits XOR parity bit must be zero
  assign w_parity_err = (r_state == PHY_PARITY) && w_tick_full && (^{r_shift, w_rxd});
  assign w_par_ok     = ~r_par_bad;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)                                     r_par_bad <= 1'b0;
    else if ((r_state == PHY_PARITY) && w_tick_full) r_par_bad <= ^{r_shift, w_rxd};
  end
`else
  assign w_parity_err = 1'b0;
  assign w_par_ok     = 1'b1;
`endif

  // Counter restarts on every state change and on every full-bit tick
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if ((r_state != w_state_nxt) || w_tick_full) r_cnt <= '0;
      else                                         r_cnt <= r_cnt + 16'd1;
      if (r_state == PHY_START) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == PHY_BITS) && w_tick_full) begin
        r_shift   <= {w_rxd, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      byte_valid <= w_byte_valid;
      frame_err  <= w_frame_err;
      parity_err <= w_parity_err;
      if (w_byte_valid) rx_byte <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_cmd_frontend.sv
`default_nettype none
// ============================================================================
// uart_rx_cmd_frontend : UART RX, escape-framing decode and FWFT command FIFO
// Parity option: UART_RX_PARITY_EN. Rev 1.0
// ============================================================================
module uart_rx_cmd_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            CLK_I,
  input  logic                            RST_NI,
  input  logic                            RXD_I,
  input  logic                            READ_I,
  output logic [7:0]                      DATA_REC_O,
  output logic                            CMD_REC_O,
  output logic                            RX_EMPTY_O,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] FILL_O,
  output logic                            FRAME_ERROR_O,
  output logic                            OVERFLOW_O,
  output logic                            PARITY_ERROR_O
);

  localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int C_FILL_W = $clog2(FIFO_DEPTH + 1);

  logic         w_byte_valid;
  logic [7:0]   w_rx_byte;
  logic         w_frame_err;
  logic         w_parity_err;

  esc_state_e   r_esc_state;
  esc_state_e   w_esc_nxt;
  logic         w_push;
  rx_entry_t    w_push_entry;

  rx_entry_t            r_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_FILL_W-1:0]  r_fill;
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_en;
  logic                 w_ovf;
  logic [C_PTR_W-1:0]   w_head_idx;

  uart_rx_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .CLK_I     (CLK_I),
    .RST_NI    (RST_NI),
    .RXD_I     (RXD_I),
    .byte_valid(w_byte_valid),
    .rx_byte   (w_rx_byte),
    .frame_err (w_frame_err),
    .parity_err(w_parity_err)
  );

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_esc_state <= S_DATA;
    else         r_esc_state <= w_esc_nxt;
  end

  // A corrupted frame cancels a pending escape
  always_comb begin
    w_esc_nxt = r_esc_state;
    if (w_frame_err || w_parity_err) begin
      w_esc_nxt = S_DATA;
    end else if (w_byte_valid) begin
      case (r_esc_state)
        S_DATA:  if (w_rx_byte == ESC_BYTE) w_esc_nxt = S_ESC;
        S_ESC:   w_esc_nxt = S_DATA;
        default: w_esc_nxt = S_DATA;
      endcase
    end
  end

  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (w_byte_valid) begin
      case (r_esc_state)
        S_DATA: begin
          w_push            = (w_rx_byte != ESC_BYTE);
          w_push_entry.data = w_rx_byte;
        end
        S_ESC: begin
          w_push            = 1'b1;
          w_push_entry.cmd  = (w_rx_byte != ESC_BYTE);
          w_push_entry.data = w_rx_byte;
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == C_FILL_W'(FIFO_DEPTH));
  assign w_pop   = READ_I && !w_empty;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovf   = w_push && w_full && !w_pop;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_fill <= r_fill + C_FILL_W'(1);
        2'b01:   r_fill <= r_fill - C_FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // When empty, the slot just behind the read pointer still holds the last popped entry
  assign w_head_idx = w_empty ? (r_rd_ptr - C_PTR_W'(1)) : r_rd_ptr;

  assign DATA_REC_O     = r_mem[w_head_idx].data;
  assign CMD_REC_O      = r_mem[w_head_idx].cmd;
  assign RX_EMPTY_O     = w_empty;
  assign FILL_O         = r_fill;
  assign FRAME_ERROR_O  = w_frame_err;
  assign OVERFLOW_O     = r_overflow;
  assign PARITY_ERROR_O = w_parity_err;

endmodule
`default_nettype wire
